uart_msg_arbiter: RTL and testbench

- Shares the single UART transmitter between NUM_REQ message sources, e.g. the LED status and 7-segment status generators.
- Each source streams ASCII bytes with a valid/ready/last handshake.
- The arbiter grants the TX path to one source for a whole message, using round-robin between messages.
- After each message it optionally appends CR LF, then drives the byte stream to the UART TX with a registered valid/ready interface.

---
 rtl/uart_msg_arbiter.sv | 148 ++++++++++++++
 tb/tb_uart_msg_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_msg_arbiter.sv
// Shares one UART transmitter between NUM_REQ message sources. Each message is
// granted whole (round-robin between messages) and optionally followed by CR LF.
module uart_msg_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int DATA_WIDTH  = 8,
    parameter int MAX_LEN     = 16,
    parameter int APPEND_CRLF = 1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          ena,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         tx_data,
    output logic                          tx_valid,
    input  logic                          tx_ready,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          busy,
    output logic                          overflow_err,
    output logic [1:0]                    dbg_state
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [7:0] CNT_LAST = 8'(MAX_LEN - 1);
    localparam logic [DATA_WIDTH-1:0] CR_BYTE = DATA_WIDTH'(8'h0D);
    localparam logic [DATA_WIDTH-1:0] LF_BYTE = DATA_WIDTH'(8'h0A);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PASS = 2'd1,
        S_CR   = 2'd2,
        S_LF   = 2'd3
    } state_t;

    // Handshakes: a byte moves on any cycle where valid && ready are both high
    // at the rising edge; valid never depends on ready, and a presented byte
    // stays stable until it is taken.
    state_t                 state_q;
    logic [NUM_REQ-1:0]     grant_q;
    logic [PTR_W-1:0]       rr_ptr_q;
    logic [7:0]             count_q;
    logic [DATA_WIDTH-1:0]  tx_data_q;
    logic                   tx_valid_q;
    logic                   ovf_q;

    logic                   out_free;
    logic                   win_found;
    logic [PTR_W-1:0]       win_idx;
    logic                   g_valid;
    logic                   g_last;
    logic [DATA_WIDTH-1:0]  g_data;
    logic                   accept;

    assign out_free = !tx_valid_q || tx_ready;

    // While a message is in flight rr_ptr_q doubles as the granted source index.
    assign g_valid = req_valid[rr_ptr_q];
    assign g_last  = req_last[rr_ptr_q];
    assign g_data  = req_data[int'(rr_ptr_q)*DATA_WIDTH +: DATA_WIDTH];
    assign accept  = ena && (state_q == S_PASS) && g_valid && out_free;

    // Round-robin search starting just after the previous winner.
    always_comb begin
        int idx;
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!win_found && req_valid[idx]) begin
                win_found = 1'b1;
                win_idx   = PTR_W'(idx);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (ena && state_q == S_PASS) begin
            req_ready[rr_ptr_q] = out_free;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= PTR_W'(NUM_REQ - 1);
            count_q    <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else if (ena) begin
            ovf_q <= 1'b0;
            // A load below overrides this drain of the output register.
            if (out_free) begin
                tx_valid_q <= 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                    if (win_found) begin
                        grant_q  <= NUM_REQ'(1) << win_idx;
                        rr_ptr_q <= win_idx;
                        count_q  <= '0;
                        state_q  <= S_PASS;
                    end
                end
                S_PASS: begin
                    if (accept) begin
                        tx_data_q  <= g_data;
                        tx_valid_q <= 1'b1;
                        count_q    <= count_q + 8'd1;
                        if (g_last || count_q == CNT_LAST) begin
                            grant_q <= '0;
                            state_q <= (APPEND_CRLF != 0) ? S_CR : S_IDLE;
                            ovf_q   <= !g_last;
                        end
                    end
                end
                S_CR: begin
                    if (out_free) begin
                        tx_data_q  <= CR_BYTE;
                        tx_valid_q <= 1'b1;
                        state_q    <= S_LF;
                    end
                end
                S_LF: begin
                    if (out_free) begin
                        tx_data_q  <= LF_BYTE;
                        tx_valid_q <= 1'b1;
                        state_q    <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign tx_data      = tx_data_q;
    assign tx_valid     = tx_valid_q && ena;
    assign grant        = grant_q;
    assign overflow_err = ovf_q && ena;
    assign busy         = (state_q != S_IDLE) || tx_valid;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_uart_msg_arbiter.sv
// Directed bench for uart_msg_arbiter: per-source driver queues feed the DUT,
// expected bytes and grants go into queues checked by an independent monitor.
module tb_uart_msg_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ena = 1'b1;
  logic        tx_ready = 1'b1;
  logic [1:0]  req_valid, req_last, req_ready, grant;
  logic [15:0] req_data;
  logic [7:0]  tx_data;
  logic        tx_valid, busy, overflow_err;
  logic [1:0]  dbg_state;

  logic       v0 = 1'b0, v1 = 1'b0, l0 = 1'b0, l1 = 1'b0;
  logic [7:0] d0 = '0, d1 = '0;
  assign req_valid = {v1, v0};
  assign req_last  = {l1, l0};
  assign req_data  = {d1, d0};

  logic [8:0] src_q0[$];
  logic [8:0] src_q1[$];
  logic [7:0] exp_q[$];
  logic [1:0] exp_grant_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rx_cnt = 0;
  int ovf_cnt = 0;
  int stall_cnt = 0;

  uart_msg_arbiter dut (
    .clk(clk), .reset_n(reset_n), .ena(ena),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .grant(grant), .busy(busy),
    .overflow_err(overflow_err), .dbg_state(dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic load_src(input int src, input string s, input bit with_last);
    logic [8:0] e;
    for (int i = 0; i < s.len(); i++) begin
      e = {with_last && (i == s.len() - 1), s[i]};
      if (src == 0) src_q0.push_back(e);
      else src_q1.push_back(e);
    end
  endtask

  task automatic expect_msg(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() + exp_grant_q.size() + src_q0.size() + src_q1.size() + int'(busy)) != 0
           && n < 400) begin
      @(negedge clk);
      n++;
    end
    check(name, exp_q.size() + exp_grant_q.size() + src_q0.size() + src_q1.size() + int'(busy), 0);
    @(posedge clk); #1;
  endtask

  task automatic wait_rx(input string name, input int target);
    int n;
    n = 0;
    while (rx_cnt < target && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, rx_cnt >= target, 1);
  endtask

  // source 0 driver
  initial begin
    bit acc;
    forever begin
      @(negedge clk);
      acc = v0 && req_ready[0] && reset_n;
      @(posedge clk); #1;
      if (acc && src_q0.size() > 0) void'(src_q0.pop_front());
      if (src_q0.size() > 0) begin
        v0 = 1'b1; {l0, d0} = src_q0[0];
      end else begin
        v0 = 1'b0; l0 = 1'b0;
      end
    end
  end

  // source 1 driver
  initial begin
    bit acc;
    forever begin
      @(negedge clk);
      acc = v1 && req_ready[1] && reset_n;
      @(posedge clk); #1;
      if (acc && src_q1.size() > 0) void'(src_q1.pop_front());
      if (src_q1.size() > 0) begin
        v1 = 1'b1; {l1, d1} = src_q1[0];
      end else begin
        v1 = 1'b0; l1 = 1'b0;
      end
    end
  end

  // monitor / scoreboard
  initial begin
    logic [7:0] e;
    logic [1:0] prev_grant;
    logic [7:0] prev_data;
    bit prev_stall;
    bit prev_ovf;
    prev_grant = '0; prev_data = '0; prev_stall = 0; prev_ovf = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_stall = 0;
        prev_ovf = 0;
      end else begin
        if (tx_valid && tx_ready) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL tx_extra: got byte %0h, expected no byte", tx_data);
          end else begin
            e = exp_q.pop_front();
            check("tx_byte", tx_data, e);
            rx_cnt++;
          end
        end
        if (prev_stall && ena) begin
          check("stall_valid", tx_valid, 1);
          check("stall_data", tx_data, prev_data);
        end
        if (tx_valid && !tx_ready) begin
          check("ready_when_full", req_ready, 0);
          stall_cnt++;
        end
        if (!ena) check("freeze_outputs", {tx_valid, req_ready, overflow_err}, 0);
        if (grant != 2'b00 && grant != prev_grant) begin
          if (exp_grant_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL grant_extra: got %0b, expected no grant", grant);
          end else begin
            check("grant_order", grant, exp_grant_q.pop_front());
          end
        end
        check("grant_onehot0", $onehot0(grant), 1);
        if (overflow_err) begin
          ovf_cnt++;
          if (prev_ovf) check("ovf_width", 2, 1);
        end
        prev_stall = tx_valid && !tx_ready && ena;
        prev_ovf = overflow_err;
        prev_data = tx_data;
      end
      prev_grant = grant;
    end
  end

  // directed tests
  initial begin
    int first_rv, first_tv, gcyc, acc_n, base, ovf_base;
    logic [1:0] sv_grant, sv_state;
    logic [7:0] sv_data;
    logic pat [4];
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", {tx_valid, grant, busy, overflow_err, req_ready, dbg_state}, 0);
    check("rst_tx_data", tx_data, 0);
    reset_n = 1'b1;

    // single message with latency and grant duration
    @(negedge clk);
    exp_grant_q.push_back(2'b01);
    load_src(0, "LD", 1);
    expect_msg("LD");
    first_rv = -1; first_tv = -1; gcyc = 0; acc_n = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (first_rv < 0 && req_valid[0]) first_rv = cyc;
      if (first_tv < 0 && tx_valid) first_tv = cyc;
      if (grant == 2'b01) gcyc++;
      if (grant == 2'b01 && req_valid[0] && req_ready[0]) acc_n++;
    end
    check("latency", first_tv - first_rv, 2);
    check("grant_cycles", gcyc, 2);
    check("accept_cycles", acc_n, 2);
    wait_drain("single_drain");

    // fairness: last winner was source 0, so source 1 goes first
    @(negedge clk);
    exp_grant_q.push_back(2'b10); exp_grant_q.push_back(2'b01);
    exp_grant_q.push_back(2'b10); exp_grant_q.push_back(2'b01);
    load_src(0, "abc", 1); load_src(0, "def", 1);
    load_src(1, "123", 1); load_src(1, "456", 1);
    expect_msg("123"); expect_msg("abc"); expect_msg("456"); expect_msg("def");
    wait_drain("fair_drain");

    // backpressure
    @(negedge clk);
    base = stall_cnt;
    exp_grant_q.push_back(2'b01);
    load_src(0, "WXYZ", 1);
    expect_msg("WXYZ");
    for (int i = 0; i < 24; i++) begin
      @(posedge clk); #1;
      tx_ready = pat[i % 4];
    end
    tx_ready = 1'b1;
    wait_drain("bp_drain");
    check("bp_stalls_seen", stall_cnt > base, 1);

    // truncation at 16 bytes, remainder as a new message
    @(negedge clk);
    ovf_base = ovf_cnt;
    exp_grant_q.push_back(2'b10); exp_grant_q.push_back(2'b10);
    for (int i = 0; i < 20; i++) begin
      src_q1.push_back({i == 19, 8'(8'h41 + i)});
      exp_q.push_back(8'(8'h41 + i));
      if (i == 15 || i == 19) begin
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
      end
    end
    wait_drain("trunc_drain");
    check("ovf_pulses", ovf_cnt - ovf_base, 1);

    // enable freeze mid-message
    @(negedge clk);
    base = rx_cnt;
    exp_grant_q.push_back(2'b01);
    load_src(0, "ENABLE", 1);
    expect_msg("ENABLE");
    wait_rx("ena_reach", base + 2);
    sv_grant = grant; sv_state = dbg_state; sv_data = tx_data; base = rx_cnt;
    ena = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("freeze_grant", grant, sv_grant);
      check("freeze_state", dbg_state, sv_state);
      check("freeze_data", tx_data, sv_data);
      @(posedge clk); #1;
    end
    check("freeze_rx", rx_cnt, base);
    ena = 1'b1;
    wait_drain("ena_drain");

    // reset during byte 3, then source 0 must win first again
    @(negedge clk);
    base = rx_cnt;
    exp_grant_q.push_back(2'b01);
    load_src(0, "RESET!", 1);
    exp_q.push_back("R"); exp_q.push_back("E"); exp_q.push_back("S");
    wait_rx("rst_reach", base + 3);
    reset_n = 1'b0;
    tx_ready = 1'b0;
    src_q0.delete();
    @(posedge clk); #1;
    check("midrst_outputs", {tx_valid, grant, busy, overflow_err, req_ready, dbg_state}, 0);
    check("midrst_tx_data", tx_data, 0);
    check("midrst_rx", rx_cnt, base + 3);
    @(posedge clk); #1;
    reset_n = 1'b1;
    tx_ready = 1'b1;
    @(negedge clk);
    exp_grant_q.push_back(2'b01); exp_grant_q.push_back(2'b10);
    load_src(0, "P0", 1); load_src(1, "Q1", 1);
    expect_msg("P0"); expect_msg("Q1");
    wait_drain("post_rst_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
